prog_mem_loader: RTL and testbench

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

---
 rtl/prog_mem_loader_if.sv | 61 ++++++
 rtl/prog_mem_loader.sv | 145 ++++++++++++++
 tb/tb_prog_mem_loader.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_loader_if.sv
// -----------------------------------------------------------------------------
// prog_mem_loader_if
//
// Bundles the CPU fetch port and the program-load byte stream of
// prog_mem_loader. Clock and reset stay plain ports on the module.
//
// Signals
//   address    [3:0]  fetch address from the CPU program counter
//   instr      [7:0]  instruction word at address (combinational read)
//   prog_en           level request to enter program-load mode
//   load_valid        load_data holds a valid byte
//   load_data  [7:0]  program byte to write
//   load_ready        loader accepts a byte this cycle
//   load_done         all 16 words written by the last load (sticky)
//   load_err          last load aborted before 16 words (sticky)
//   cpu_run           CPU may execute; drives the CPU's active-low reset
//
// Handshake: a byte transfers on a rising clk edge where load_valid and
// load_ready are both 1. load_ready depends only on the loader's state
// register, never on load_valid, so the source may hold or change
// load_data/load_valid freely between transfers.
//
// Modports
//   master : the side supplying address and the load stream (CPU + host)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface prog_mem_loader_if;
  logic [3:0] address;
  logic [7:0] instr;
  logic       prog_en;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic       load_err;
  logic       cpu_run;

  modport master (
    output address,
    output prog_en,
    output load_valid,
    output load_data,
    input  instr,
    input  load_ready,
    input  load_done,
    input  load_err,
    input  cpu_run
  );

  modport slave (
    input  address,
    input  prog_en,
    input  load_valid,
    input  load_data,
    output instr,
    output load_ready,
    output load_done,
    output load_err,
    output cpu_run
  );
endinterface

// File: rtl/prog_mem_loader.sv
// -----------------------------------------------------------------------------
// prog_mem_loader
//
// 16 x 8 program memory for a small CPU with a byte-stream loader in front
// of it. The CPU reads instr = mem[address] combinationally at all times.
// While prog_en is high the loader holds the CPU in reset (cpu_run = 0) and
// writes incoming bytes to consecutive words starting at word 0.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   bus        prog_mem_loader_if.slave (fetch port + load stream)
//   dbg_state  current FSM state (0 = RUN, 1 = LOAD, 2 = DONE)
//
// Configuration
//   PROG_MEM_DEFAULT_ROM_EN  when defined, reset loads a small boot image
//                            (B1 01 F0 followed by zeros); otherwise reset
//                            clears all 16 words to 00.
//
// States
//   RUN  : CPU runs, memory is read-only. prog_en=1 moves to LOAD and
//          clears the write pointer and both status flags.
//   LOAD : load_ready=1; each handshake writes mem[wr_ptr] and bumps
//          wr_ptr. The write of word 15 completes the load (-> DONE).
//          prog_en=0 here aborts back to RUN with load_err set; a byte
//          presented on that same edge is still written.
//   DONE : load complete, further bytes ignored; waits for prog_en=0.
// -----------------------------------------------------------------------------
module prog_mem_loader (
  input  logic                clk,
  input  logic                reset,
  prog_mem_loader_if.slave    bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reset contents, word 0 in the least significant byte.
`ifdef PROG_MEM_DEFAULT_ROM_EN
  localparam logic [127:0] RESET_IMAGE = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h01, 8'hB1
  };
`else
  localparam logic [127:0] RESET_IMAGE = '0;
`endif

  state_t     state;
  state_t     next_state;
  logic [7:0] mem [16];
  logic [3:0] wr_ptr;
  logic       load_done_q;
  logic       load_err_q;
  logic       cpu_run_q;

  logic       wr_en;
  logic       last_word;

  // load_ready is a pure state decode, so the write enable only needs the
  // source's valid on top of it.
  assign wr_en     = (state == ST_LOAD) && bus.load_valid;
  assign last_word = (wr_ptr == 4'hF);

  // ---------------------------------------------------------------------------
  // Next-state decode. cpu_run is registered from this, so it changes on the
  // very edge that enters or leaves RUN.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (bus.prog_en) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (!bus.prog_en)           next_state = ST_RUN;
        else if (wr_en && last_word) next_state = ST_DONE;
      end
      ST_DONE: begin
        if (!bus.prog_en) next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, pointer, flags and storage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      wr_ptr      <= 4'd0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      cpu_run_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= RESET_IMAGE[i*8 +: 8];
      end
    end else begin
      state     <= next_state;
      cpu_run_q <= (next_state == ST_RUN);

      if (wr_en) begin
        mem[wr_ptr] <= bus.load_data;
        wr_ptr      <= wr_ptr + 4'd1;   // wraps 15 -> 0 after the last word
      end

      case (state)
        ST_RUN: begin
          // Flags stay sticky in RUN until a new load starts.
          if (bus.prog_en) begin
            wr_ptr      <= 4'd0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
          end
        end
        ST_LOAD: begin
          // If the final word lands on the same edge prog_en drops, the
          // image is complete, so report done rather than an abort.
          if (wr_en && last_word) begin
            load_done_q <= 1'b1;
          end else if (!bus.prog_en) begin
            load_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. instr is a plain mux so a word being written this cycle still
  // reads its old value until the write edge.
  // ---------------------------------------------------------------------------
  assign bus.instr      = mem[bus.address];
  assign bus.load_ready = (state == ST_LOAD);
  assign bus.load_done  = load_done_q;
  assign bus.load_err   = load_err_q;
  assign bus.cpu_run    = cpu_run_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_prog_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_mem_loader
//
// Bench for prog_mem_loader. Inputs are driven 1 ns after the rising edge
// and outputs are sampled there as well. The reference is a plain 16-byte
// array: byte k of a load lands in word k, reset restores the reset image.
// Build with +define+PROG_MEM_DEFAULT_ROM_EN to exercise the boot image.
// -----------------------------------------------------------------------------
module tb_prog_mem_loader;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  prog_mem_loader_if bus ();

  prog_mem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model_mem [16];
  logic [7:0] load_bytes [16];
  logic [7:0] exp_q [$];

  function automatic logic [7:0] rom_word(input int idx);
`ifdef PROG_MEM_DEFAULT_ROM_EN
    case (idx)
      0:       rom_word = 8'hB1;
      1:       rom_word = 8'h01;
      2:       rom_word = 8'hF0;
      default: rom_word = 8'h00;
    endcase
`else
    rom_word = (idx < 0) ? 8'hFF : 8'h00;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = rom_word(i);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_load();
    bus.prog_en = 1'b1;
    tick();
  endtask

  // Streams load_bytes[0..n-1] with the given valid pattern
  // (0 = always valid, 1 = every other cycle, 2 = random). Bounded to 200
  // cycles; callers compare 'accepted' against n.
  task automatic drive_load(input int n, input int mode,
                            output int accepted, output int ready_cycles,
                            output int cycles, output bit done_early);
    logic v;
    accepted     = 0;
    ready_cycles = 0;
    cycles       = 0;
    done_early   = 1'b0;
    while (accepted < n && cycles < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cycles % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.load_valid = v;
      bus.load_data  = v ? load_bytes[accepted] : 8'($urandom);
      #1;
      if (bus.load_ready) ready_cycles++;
      if (bus.load_done) done_early = 1'b1;
      if (bus.load_ready && v) begin
        model_mem[accepted] = bus.load_data;
        exp_q.push_back(bus.load_data);
        accepted++;
      end
      tick();
      cycles++;
    end
    bus.load_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    model_reset();
    #2;
    n_checks++; if (bus.cpu_run !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_run: got %0b want 0", bus.cpu_run); end
    n_checks++; if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %0b want 0", bus.load_done); end
    n_checks++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL reset_load_err: got %0b want 0", bus.load_err); end
    n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_load_ready: got %0b want 0", bus.load_ready); end
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_checks++;
      if (bus.instr !== model_mem[a]) begin
        n_fail++; $display("FAIL reset_image addr %0d: got %02h want %02h", a, bus.instr, model_mem[a]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++; if (bus.cpu_run !== 1'b1) begin n_fail++; $display("FAIL reset_release_cpu_run: got %0b want 1", bus.cpu_run); end
  endtask

  task automatic test_stream_load();
    int acc, rdy, cyc;
    bit early;
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'h10 + 8'(i);
    exp_q.delete();
    enter_load();
    n_checks++; if (bus.cpu_run !== 1'b0) begin n_fail++; $display("FAIL stream_enter_cpu_run: got %0b want 0", bus.cpu_run); end
    drive_load(16, 0, acc, rdy, cyc, early);
    n_checks++; if (acc !== 16) begin n_fail++; $display("FAIL stream_accepted: got %0d want 16", acc); end
    n_checks++; if (rdy !== 16) begin n_fail++; $display("FAIL stream_ready_cycles: got %0d want 16", rdy); end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL stream_done_early: got %0b want 0", early); end
    n_checks++; if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL stream_load_done: got %0b want 1", bus.load_done); end
    n_checks++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL stream_load_err: got %0b want 0", bus.load_err); end
    // prog_en still high: stays DONE with the CPU held.
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL stream_done_ready cyc %0d: got %0b want 0", k, bus.load_ready); end
      n_checks++; if (bus.cpu_run !== 1'b0) begin n_fail++; $display("FAIL stream_done_cpu_run cyc %0d: got %0b want 0", k, bus.cpu_run); end
      tick();
    end
    bus.prog_en = 1'b0;
    tick();
    n_checks++; if (bus.cpu_run !== 1'b1) begin n_fail++; $display("FAIL stream_exit_cpu_run: got %0b want 1", bus.cpu_run); end
    n_checks++; if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL stream_sticky_done: got %0b want 1", bus.load_done); end
    bus.address = 4'd5;
    #1;
    n_checks++; if (bus.instr !== 8'h15) begin n_fail++; $display("FAIL stream_addr5: got %02h want 15", bus.instr); end
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_checks++;
      if (bus.instr !== exp_q[a]) begin
        n_fail++; $display("FAIL stream_word %0d: got %02h want %02h", a, bus.instr, exp_q[a]);
      end
    end
  endtask

  task automatic test_toggle_load();
    int acc, rdy, cyc;
    bit early;
    logic [7:0] e;
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom);
    exp_q.delete();
    enter_load();
    drive_load(16, 1, acc, rdy, cyc, early);
    n_checks++; if (acc !== 16) begin n_fail++; $display("FAIL toggle_accepted: got %0d want 16", acc); end
    n_checks++; if (cyc !== 31) begin n_fail++; $display("FAIL toggle_cycles: got %0d want 31", cyc); end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL toggle_done_early: got %0b want 0", early); end
    n_checks++; if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL toggle_load_done: got %0b want 1", bus.load_done); end
    bus.prog_en = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) begin
      e = exp_q.pop_front();
      bus.address = 4'(a);
      #1;
      n_checks++;
      if (bus.instr !== e) begin
        n_fail++; $display("FAIL toggle_word %0d: got %02h want %02h", a, bus.instr, e);
      end
    end
  endtask

  task automatic test_random_load_and_done_ignore();
    int acc, rdy, cyc;
    bit early;
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom);
    exp_q.delete();
    enter_load();
    drive_load(16, 2, acc, rdy, cyc, early);
    n_checks++; if (acc !== 16) begin n_fail++; $display("FAIL random_accepted: got %0d want 16", acc); end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL random_done_early: got %0b want 0", early); end
    // In DONE, a held valid with FF must not touch any word.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL done_ignore_ready cyc %0d: got %0b want 0", k, bus.load_ready); end
      tick();
    end
    bus.load_valid = 1'b0;
    bus.prog_en    = 1'b0;
    tick();
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_checks++;
      if (bus.instr !== model_mem[a]) begin
        n_fail++; $display("FAIL done_ignore_word %0d: got %02h want %02h", a, bus.instr, model_mem[a]);
      end
    end
  endtask

  task automatic test_abort();
    int acc, rdy, cyc;
    bit early;
    for (int i = 0; i < 5; i++) load_bytes[i] = 8'hA0 + 8'(i);
    exp_q.delete();
    enter_load();
    drive_load(4, 0, acc, rdy, cyc, early);
    n_checks++; if (acc !== 4) begin n_fail++; $display("FAIL abort_accepted: got %0d want 4", acc); end
    // Fifth byte rides on the same edge that drops prog_en.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hA4;
    bus.prog_en    = 1'b0;
    model_mem[4]   = 8'hA4;
    tick();
    bus.load_valid = 1'b0;
    n_checks++; if (bus.load_err !== 1'b1) begin n_fail++; $display("FAIL abort_load_err: got %0b want 1", bus.load_err); end
    n_checks++; if (bus.load_done !== 1'b0) begin n_fail++; $display("FAIL abort_load_done: got %0b want 0", bus.load_done); end
    n_checks++; if (bus.cpu_run !== 1'b1) begin n_fail++; $display("FAIL abort_cpu_run: got %0b want 1", bus.cpu_run); end
    repeat (3) tick();
    n_checks++; if (bus.load_err !== 1'b1) begin n_fail++; $display("FAIL abort_sticky_err: got %0b want 1", bus.load_err); end
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_checks++;
      if (bus.instr !== model_mem[a]) begin
        n_fail++; $display("FAIL abort_word %0d: got %02h want %02h", a, bus.instr, model_mem[a]);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [7:0] old_v;
    enter_load();
    n_checks++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL rdw_err_cleared: got %0b want 0", bus.load_err); end
    bus.address    = 4'd0;
    old_v          = model_mem[0];
    bus.load_valid = 1'b1;
    bus.load_data  = ~old_v;
    #1;
    n_checks++; if (bus.instr !== old_v) begin n_fail++; $display("FAIL rdw_pre_edge: got %02h want %02h", bus.instr, old_v); end
    tick();
    bus.load_valid = 1'b0;
    model_mem[0]   = ~old_v;
    n_checks++; if (bus.instr !== model_mem[0]) begin n_fail++; $display("FAIL rdw_post_edge: got %02h want %02h", bus.instr, model_mem[0]); end
    bus.prog_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    int acc, rdy, cyc;
    bit early;
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'($urandom) | 8'h01;
    enter_load();
    n_checks++; if (bus.load_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err_cleared: got %0b want 0", bus.load_err); end
    drive_load(3, 0, acc, rdy, cyc, early);
    bus.address = 4'd0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++; if (bus.instr !== model_mem[0]) begin n_fail++; $display("FAIL midrst_addr0: got %02h want %02h", bus.instr, model_mem[0]); end
    n_checks++; if (bus.cpu_run !== 1'b0) begin n_fail++; $display("FAIL midrst_cpu_run: got %0b want 0", bus.cpu_run); end
    n_checks++; if (bus.load_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %0b want 0", bus.load_ready); end
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      n_checks++;
      if (bus.instr !== model_mem[a]) begin
        n_fail++; $display("FAIL midrst_word %0d: got %02h want %02h", a, bus.instr, model_mem[a]);
      end
    end
    bus.prog_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++; if (bus.cpu_run !== 1'b1) begin n_fail++; $display("FAIL midrst_release_cpu_run: got %0b want 1", bus.cpu_run); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    bus.address    = 4'd0;
    bus.prog_en    = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    test_reset();
    test_stream_load();
    test_toggle_load();
    test_random_load_and_done_ignore();
    test_abort();
    test_read_during_write();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
